// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle MIPS control unit. A Moore FSM steps one state per
//               datapath cycle, decoding op/funct from the instruction register
//               and driving the ALU control and the datapath selects/enables.
//               Memory-access states (FETCH, MEMRD, MEMWR) can be stretched by
//               MEM_WAIT extra cycles. Optional macro BNE_EN adds a bne state.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
  parameter int MEM_WAIT = 0  // extra cycles per memory-access state, 0..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       lord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BRANCHNE = 4'd12
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  localparam logic [3:0] C_WAIT = 4'(MEM_WAIT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       w_final;

  // Enables before reset gating; these must never fire while reset is held.
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_pcen;

  assign w_final = (r_cnt == C_WAIT);

  // State register and wait counter; the counter restarts on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= 4'd0;
      else                   r_cnt <= r_cnt + 4'd1;
    end
  end

  // Next-state and Moore output decode; pcen also follows zero in branch states.
  always_comb begin
    w_next     = S_FETCH;
    alucontrol = 3'b000;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    lord       = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    pcsrc      = 2'b00;
    w_pcen     = 1'b0;

    case (r_state)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = C_ALU_ADD;
        if (w_final) begin
          w_irwrite = 1'b1;
          w_pcen    = 1'b1;
          w_next    = S_DECODE;
        end else begin
          w_next    = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = C_ALU_ADD;
        case (op)
          C_OP_LW, C_OP_SW: w_next = S_MEMADR;
          C_OP_RTYPE:       w_next = S_EXECUTE;
          C_OP_BEQ:         w_next = S_BRANCH;
          C_OP_ADDI:        w_next = S_ADDIEX;
          C_OP_J:           w_next = S_JUMP;
`ifdef BNE_EN
          C_OP_BNE:         w_next = S_BRANCHNE;
`endif
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = C_ALU_ADD;
        w_next     = (op == C_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        lord   = 1'b1;
        w_next = w_final ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        lord       = 1'b1;
        w_memwrite = w_final;
        w_next     = w_final ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_next  = S_ALUWB;
        case (funct)
          6'b100000: alucontrol = C_ALU_ADD;
          6'b100010: alucontrol = C_ALU_SUB;
          6'b100100: alucontrol = C_ALU_AND;
          6'b100101: alucontrol = C_ALU_OR;
          6'b101010: alucontrol = C_ALU_SLT;
          default: begin
            // Unsupported funct retires as a nop: no writeback.
            alucontrol = C_ALU_ADD;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = C_ALU_SUB;
        pcsrc      = 2'b01;
        w_pcen     = zero;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = C_ALU_ADD;
        w_next     = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        w_pcen = 1'b1;
      end
`ifdef BNE_EN
      S_BRANCHNE: begin
        alusrca    = 1'b1;
        alucontrol = C_ALU_SUB;
        pcsrc      = 2'b01;
        w_pcen     = ~zero;
      end
`endif
      default: begin
        // Unused encodings: all outputs idle, recover to FETCH.
        w_next = S_FETCH;
      end
    endcase
  end

  assign irwrite  = w_irwrite  & reset;
  assign memwrite = w_memwrite & reset;
  assign regwrite = w_regwrite & reset;
  assign pcen     = w_pcen     & reset;
  assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Scoreboard bench for mc_control_fsm. Two instances run in
//               parallel (MEM_WAIT=0 and MEM_WAIT=3). Random instructions are
//               expanded into per-cycle expected output timelines; a monitor
//               compares every cycle on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

  localparam int N_INSTR = 60;
  localparam int ABORT_N = 20;

  logic       clk = 1'b0;
  logic       rstn  [2];
  logic [5:0] op    [2];
  logic [5:0] funct [2];
  logic       zero  [2];
  logic [2:0] aluc  [2];
  logic       srca  [2];
  logic [1:0] srcb  [2];
  logic       lord  [2];
  logic       irw   [2];
  logic       memw  [2];
  logic       regdst[2];
  logic       m2r   [2];
  logic       regw  [2];
  logic [1:0] pcsrc [2];
  logic       pcen  [2];
  logic [3:0] st    [2];

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(rstn[0]), .op(op[0]), .funct(funct[0]), .zero(zero[0]),
    .alucontrol(aluc[0]), .alusrca(srca[0]), .alusrcb(srcb[0]), .lord(lord[0]),
    .irwrite(irw[0]), .memwrite(memw[0]), .regdst(regdst[0]), .memtoreg(m2r[0]),
    .regwrite(regw[0]), .pcsrc(pcsrc[0]), .pcen(pcen[0]), .state(st[0])
  );

  mc_control_fsm #(.MEM_WAIT(3)) u_dut3 (
    .clk(clk), .reset(rstn[1]), .op(op[1]), .funct(funct[1]), .zero(zero[1]),
    .alucontrol(aluc[1]), .alusrca(srca[1]), .alusrcb(srcb[1]), .lord(lord[1]),
    .irwrite(irw[1]), .memwrite(memw[1]), .regdst(regdst[1]), .memtoreg(m2r[1]),
    .regwrite(regw[1]), .pcsrc(pcsrc[1]), .pcen(pcen[1]), .state(st[1])
  );

  typedef struct packed {
    logic [3:0] state;
    logic [2:0] aluc;
    logic       srca;
    logic [1:0] srcb;
    logic       lord;
    logic       irw;
    logic       memw;
    logic       regdst;
    logic       m2r;
    logic       regw;
    logic [1:0] pcsrc;
    logic       pcen;
  } outs_t;

  // pmode: 0 pcen fixed, 1 pcen = zero, 2 pcen = ~zero
  typedef struct packed {
    outs_t      o;
    logic [1:0] pmode;
  } plan_t;

  plan_t pl[2][$];
  outs_t sb[2][$];
  int    total = 0;
  int    bad   = 0;

  function automatic int mwv(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Argument order: state, alucontrol, alusrca, alusrcb, lord, irwrite,
  // memwrite, regdst, memtoreg, regwrite, pcsrc, pcen, pcen mode.
  function automatic plan_t mk(input int s, input int ac, input int sa, input int sbv,
                               input int ld, input int iw, input int mw, input int rd,
                               input int mr, input int rw, input int ps, input int pe,
                               input int pm);
    plan_t p;
    p.o.state  = 4'(s);
    p.o.aluc   = 3'(ac);
    p.o.srca   = 1'(sa);
    p.o.srcb   = 2'(sbv);
    p.o.lord   = 1'(ld);
    p.o.irw    = 1'(iw);
    p.o.memw   = 1'(mw);
    p.o.regdst = 1'(rd);
    p.o.m2r    = 1'(mr);
    p.o.regw   = 1'(rw);
    p.o.pcsrc  = 2'(ps);
    p.o.pcen   = 1'(pe);
    p.pmode    = 2'(pm);
    return p;
  endfunction

  function automatic outs_t actual(input int k);
    outs_t a;
    a = {st[k], aluc[k], srca[k], srcb[k], lord[k], irw[k], memw[k],
         regdst[k], m2r[k], regw[k], pcsrc[k], pcen[k]};
    return a;
  endfunction

  // Expand one instruction into its expected cycle-by-cycle timeline.
  task automatic build(input int k, input logic [5:0] o, input logic [5:0] f);
    int w;
    int ac;
    int known;
    w = mwv(k);
    for (int i = 0; i <= w; i++)
      pl[k].push_back(mk(0, 2, 0, 1, 0, (i == w) ? 1 : 0, 0, 0, 0, 0, 0, (i == w) ? 1 : 0, 0));
    pl[k].push_back(mk(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (o)
      6'b100011: begin // lw
        pl[k].push_back(mk(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i <= w; i++)
          pl[k].push_back(mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        pl[k].push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      end
      6'b101011: begin // sw
        pl[k].push_back(mk(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i <= w; i++)
          pl[k].push_back(mk(5, 0, 0, 0, 1, 0, (i == w) ? 1 : 0, 0, 0, 0, 0, 0, 0));
      end
      6'b000000: begin // R-type
        known = 1;
        case (f)
          6'b100000: ac = 2;
          6'b100010: ac = 6;
          6'b100100: ac = 0;
          6'b100101: ac = 1;
          6'b101010: ac = 7;
          default: begin ac = 2; known = 0; end
        endcase
        pl[k].push_back(mk(6, ac, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (known == 1)
          pl[k].push_back(mk(7, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
      end
      6'b000100: pl[k].push_back(mk(8, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1)); // beq
      6'b001000: begin // addi
        pl[k].push_back(mk(9, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        pl[k].push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      end
      6'b000010: pl[k].push_back(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0)); // j
`ifdef BNE_EN
      6'b000101: pl[k].push_back(mk(12, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2)); // bne
`endif
      default: ; // unknown op: back to FETCH after DECODE
    endcase
  endtask

  function automatic logic [5:0] pick_funct();
    int r;
    r = int'($urandom_range(0, 5));
    case (r)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_op(input int n);
    int sel;
    sel = (n < 7) ? n : int'($urandom_range(0, 7));
    if (n == ABORT_N) sel = 0;
    case (sel)
      0: return 6'b100011;
      1: return 6'b101011;
      2: return 6'b000000;
      3: return 6'b000000;
      4: return 6'b000100;
      5: return 6'b001000;
      6: return 6'b000101;
      default: return (n < 7) ? 6'b000010 : 6'($urandom);
    endcase
  endfunction

  task automatic run(input int k);
    plan_t      p;
    outs_t      e;
    logic [5:0] o;
    logic [5:0] f;
    logic       want;
    rstn[k]  = 1'b0;
    op[k]    = 6'b000000;
    funct[k] = 6'b000000;
    zero[k]  = 1'b0;
    @(posedge clk);
    // Reset held: FETCH datapath selects visible, all enables suppressed.
    repeat (3) begin
      #1;
      e = mk(0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0).o;
      sb[k].push_back(e);
      @(posedge clk);
    end
    for (int n = 0; n < N_INSTR; n++) begin
      o = pick_op(n);
      if (n == 2)      f = 6'b101010;
      else if (n == 3) f = 6'b111111;
      else             f = pick_funct();
      build(k, o, f);
      while (pl[k].size() > 0) begin
        #1;
        rstn[k]  = 1'b1;
        op[k]    = o;
        funct[k] = f;
        zero[k]  = 1'($urandom_range(0, 1));
        p = pl[k].pop_front();
        if (p.pmode == 2'd1)      p.o.pcen = zero[k];
        else if (p.pmode == 2'd2) p.o.pcen = ~zero[k];
        sb[k].push_back(p.o);
        if (p.pmode != 2'd0) begin
          @(negedge clk);
          #2;
          zero[k] = ~zero[k];
          #1;
          want = (p.pmode == 2'd1) ? zero[k] : ~zero[k];
          total++;
          if (pcen[k] !== want) begin
            bad++;
            $display("FAIL pcen_follows_zero k=%0d actual=%b required=%b", k, pcen[k], want);
          end
        end
        if (n == ABORT_N && p.o.state == 4'd3) begin
          @(negedge clk);
          #2;
          rstn[k] = 1'b0;
          #1;
          total++;
          if (st[k] !== 4'd0 || irw[k] !== 1'b0 || memw[k] !== 1'b0 ||
              regw[k] !== 1'b0 || pcen[k] !== 1'b0) begin
            bad++;
            $display("FAIL async_reset k=%0d actual state=%0d en=%b%b%b%b required state=0 en=0000",
                     k, st[k], irw[k], memw[k], regw[k], pcen[k]);
          end
          pl[k].delete();
        end
        @(posedge clk);
      end
    end
  endtask

  // Monitor: every falling edge, compare the full output vector of each DUT.
  always @(negedge clk) begin
    outs_t e;
    outs_t a;
    for (int k = 0; k < 2; k++) begin
      if (sb[k].size() != 0) begin
        e = sb[k].pop_front();
        a = actual(k);
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle_outputs k=%0d t=%0t actual=%h required=%h (state %0d vs %0d)",
                   k, $time, a, e, a.state, e.state);
        end
      end
    end
  end

  initial begin
    fork
      run(0);
      run(1);
    join
    @(negedge clk);
    #1;
    total++;
    if (sb[0].size() + sb[1].size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb[0].size() + sb[1].size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
